// File: rtl/vga_timing_gen_if.sv
// Timing bundle between vga_timing_gen and its consumers (character fetch + video DAC).
// Port widths derive from the raster geometry so both ends agree by construction.
interface vga_timing_gen_if #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CELL_W   = 8,
  parameter int CELL_H   = 8
);
  localparam int PXW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int PYW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int CCW = (H_ACTIVE / CELL_W > 0) ? $clog2(H_ACTIVE / CELL_W + 1) : 1;
  localparam int CRW = (V_ACTIVE / CELL_H > 0) ? $clog2(V_ACTIVE / CELL_H + 1) : 1;
  localparam int SXW = $clog2(CELL_W + 1);
  localparam int SYW = $clog2(CELL_H + 1);

  logic [PXW-1:0] posx;
  logic [PYW-1:0] posy;
  logic [CCW-1:0] cell_col;
  logic [CRW-1:0] cell_row;
  logic [SXW-1:0] sub_x;
  logic [SYW-1:0] sub_y;
  logic           fetch_de_o;
  logic           line_start_o;
  logic           frame_start_o;
  logic           de_o;
  logic           h_sync_o;
  logic           v_sync_o;
  logic           vblank_irq_o;
  logic           irq_ack;

  modport master (
    input  irq_ack,
    output posx, posy, cell_col, cell_row, sub_x, sub_y,
           fetch_de_o, line_start_o, frame_start_o,
           de_o, h_sync_o, v_sync_o, vblank_irq_o
  );

  modport slave (
    output irq_ack,
    input  posx, posy, cell_col, cell_row, sub_x, sub_y,
           fetch_de_o, line_start_o, frame_start_o,
           de_o, h_sync_o, v_sync_o, vblank_irq_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: fetch-side coordinates one cycle after the counters,
// display-side DE/syncs a further LEAD cycles later so RAM read latency is hidden.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int LEAD     = 2,
  parameter int CELL_W   = 8,
  parameter int CELL_H   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL + 1);
  localparam int VW  = $clog2(V_TOTAL + 1);
  localparam int PXW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int PYW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int CRW = (V_ACTIVE / CELL_H > 0) ? $clog2(V_ACTIVE / CELL_H + 1) : 1;
  localparam int SXW = $clog2(CELL_W + 1);
  localparam int SYW = $clog2(CELL_H + 1);

  localparam logic [HW-1:0]  H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SXW-1:0] SX_LAST = SXW'(CELL_W - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(CELL_H - 1);
  localparam logic           H_IDLE  = (H_POL == 0);
  localparam logic           V_IDLE  = (V_POL == 0);

  // Raw (active-high) timing that travels down the display pipeline.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } tim_t;

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [SYW-1:0] row_sub;
  logic [CRW-1:0] row_idx;
  logic           h_wrap, v_wrap, active, hs_raw, vs_raw;
  tim_t           fetch_tim, disp_tim;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Cell row tracking for the line the counters are on; advanced only through active lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sub <= '0;
      row_idx <= '0;
    end else if (!en || (h_wrap && v_wrap)) begin
      row_sub <= '0;
      row_idx <= '0;
    end else if (h_wrap && (v_cnt < V_ACT)) begin
      if (row_sub == SY_LAST) begin
        row_sub <= '0;
        row_idx <= row_idx + 1'b1;
      end else begin
        row_sub <= row_sub + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_tim         <= '0;
      vif.posx          <= '0;
      vif.posy          <= '0;
      vif.sub_x         <= '0;
      vif.cell_col      <= '0;
      vif.sub_y         <= '0;
      vif.cell_row      <= '0;
      vif.line_start_o  <= 1'b0;
      vif.frame_start_o <= 1'b0;
    end else if (!en) begin
      fetch_tim         <= '0;
      vif.posx          <= '0;
      vif.posy          <= '0;
      vif.sub_x         <= '0;
      vif.cell_col      <= '0;
      vif.sub_y         <= '0;
      vif.cell_row      <= '0;
      vif.line_start_o  <= 1'b0;
      vif.frame_start_o <= 1'b0;
    end else begin
      fetch_tim         <= '{de: active, hs: hs_raw, vs: vs_raw};
      vif.posx          <= active ? PXW'(h_cnt) : '0;
      vif.posy          <= active ? PYW'(v_cnt) : '0;
      vif.sub_y         <= active ? row_sub : '0;
      vif.cell_row      <= active ? row_idx : '0;
      vif.line_start_o  <= (h_cnt == '0) && (v_cnt < V_ACT);
      vif.frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
      // The column counters step from their own registered value; h_cnt==0 restarts them.
      if (!active || (h_cnt == '0)) begin
        vif.sub_x    <= '0;
        vif.cell_col <= '0;
      end else if (vif.sub_x == SX_LAST) begin
        vif.sub_x    <= '0;
        vif.cell_col <= vif.cell_col + 1'b1;
      end else begin
        vif.sub_x    <= vif.sub_x + 1'b1;
      end
    end
  end

  // A set request outranks a coincident acknowledge so no vblank is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vif.vblank_irq_o <= 1'b0;
    end else if (en && (h_cnt == '0) && (v_cnt == V_ACT)) begin
      vif.vblank_irq_o <= 1'b1;
    end else if (vif.irq_ack) begin
      vif.vblank_irq_o <= 1'b0;
    end
  end

  generate
    if (LEAD == 0) begin : g_no_lead
      assign disp_tim = fetch_tim;
    end else begin : g_lead
      tim_t pipe [LEAD];
      // NOTE: this delay line is reset (unlike a RAM) so the display pins are quiet right after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LEAD; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= fetch_tim;
          for (int i = 1; i < LEAD; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign disp_tim = pipe[LEAD-1];
    end
  endgenerate

  assign vif.fetch_de_o = fetch_tim.de;
  assign vif.de_o       = disp_tim.de;
  assign vif.h_sync_o   = disp_tim.hs ^ H_IDLE;
  assign vif.v_sync_o   = disp_tim.vs ^ V_IDLE;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a small raster instance checked every cycle against
// an arithmetic position model, a polarity-inverted twin, and a default-geometry line check.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int CW = 4, CH = 2, LEAD = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic en = 1'b0;
  logic en2 = 1'b1;
  logic irq_ack = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CELL_W(CW), .CELL_H(CH)) if0 ();
  vga_timing_gen_if #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CELL_W(CW), .CELL_H(CH)) if1 ();
  vga_timing_gen_if if2 ();

  assign if0.irq_ack = irq_ack;
  assign if1.irq_ack = irq_ack;
  assign if2.irq_ack = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(0), .V_POL(0), .LEAD(LEAD), .CELL_W(CW), .CELL_H(CH)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .en(en), .vif(if0));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1), .V_POL(1), .LEAD(LEAD), .CELL_W(CW), .CELL_H(CH)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .en(en), .vif(if1));

  vga_timing_gen u_dut2 (.clk(clk), .rst_n(rst_n), .en(en2), .vif(if2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: raster position p counts enabled cycles since (0,0); everything else is
  // derived from p with plain division/modulo.
  int p;
  int m_h, m_v;
  bit m_act;
  bit e_fde, e_ls, e_fs, f_hs, f_vs, e_irq;
  int e_posx, e_posy, e_subx, e_suby, e_ccol, e_crow;
  bit hist_de [LEAD];
  bit hist_hs [LEAD];
  bit hist_vs [LEAD];

  task automatic model_idle();
    e_fde = 0; e_ls = 0; e_fs = 0; f_hs = 0; f_vs = 0;
    e_posx = 0; e_posy = 0; e_subx = 0; e_suby = 0; e_ccol = 0; e_crow = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p = 0;
      e_irq = 0;
      model_idle();
      for (int i = 0; i < LEAD; i++) begin
        hist_de[i] = 0; hist_hs[i] = 0; hist_vs[i] = 0;
      end
    end else begin
      m_h = p % HT;
      m_v = p / HT;
      for (int i = LEAD - 1; i > 0; i--) begin
        hist_de[i] = hist_de[i-1]; hist_hs[i] = hist_hs[i-1]; hist_vs[i] = hist_vs[i-1];
      end
      hist_de[0] = e_fde; hist_hs[0] = f_hs; hist_vs[0] = f_vs;
      if (en && m_h == 0 && m_v == VA) e_irq = 1;
      else if (irq_ack) e_irq = 0;
      if (en) begin
        m_act  = (m_h < HA) && (m_v < VA);
        e_fde  = m_act;
        e_posx = m_act ? m_h : 0;
        e_posy = m_act ? m_v : 0;
        e_subx = m_act ? m_h % CW : 0;
        e_ccol = m_act ? m_h / CW : 0;
        e_suby = m_act ? m_v % CH : 0;
        e_crow = m_act ? m_v / CH : 0;
        e_ls   = (m_h == 0) && (m_v < VA);
        e_fs   = (m_h == 0) && (m_v == 0);
        f_hs   = (m_h >= HA + HF) && (m_h < HA + HF + HS);
        f_vs   = (m_v >= VA + VF) && (m_v < VA + VF + VS);
        p = (p + 1) % (HT * VT);
      end else begin
        model_idle();
        p = 0;
      end
    end
  end

  task automatic check_all();
    check("fetch_de", if0.fetch_de_o, e_fde);
    check("posx", if0.posx, e_posx);
    check("posy", if0.posy, e_posy);
    check("sub_x", if0.sub_x, e_subx);
    check("cell_col", if0.cell_col, e_ccol);
    check("sub_y", if0.sub_y, e_suby);
    check("cell_row", if0.cell_row, e_crow);
    check("line_start", if0.line_start_o, e_ls);
    check("frame_start", if0.frame_start_o, e_fs);
    check("de", if0.de_o, hist_de[LEAD-1]);
    check("h_sync", if0.h_sync_o, !hist_hs[LEAD-1]);
    check("v_sync", if0.v_sync_o, !hist_vs[LEAD-1]);
    check("vblank_irq", if0.vblank_irq_o, e_irq);
    check("h_sync_pol1", if1.h_sync_o, hist_hs[LEAD-1]);
    check("v_sync_pol1", if1.v_sync_o, hist_vs[LEAD-1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    while (p != target && n < 4 * HT * VT) begin
      cycle();
      n++;
    end
    if (p != target) check("wait_pos_timeout", p, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fde_cnt, hs_low, vs_low, fs1, fs2, irq_rise;
    int r1, r2, hfall, hrise, vs2_low, de2_cnt;
    logic prev_de, prev_hs;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_all();
    check("rst_h_sync_pol1", if1.h_sync_o, 0);
    check("rst_v_sync_pol1", if1.v_sync_o, 0);
    check("rst_h_sync", if0.h_sync_o, 1);
    repeat (2) @(negedge clk);
    en = 1'b1;
    rst_n = 1'b1;

    // Two frames from reset release with en high.
    fde_cnt = 0; hs_low = 0; vs_low = 0; fs1 = -1; fs2 = -1; irq_rise = -1;
    for (int cyc = 1; cyc <= 2 * HT * VT; cyc++) begin
      cycle();
      if (cyc <= HT * VT && if0.fetch_de_o) fde_cnt++;
      if (cyc >= 1 + LEAD && cyc <= HT * VT + LEAD) begin
        if (!if0.h_sync_o) hs_low++;
        if (!if0.v_sync_o) vs_low++;
      end
      if (if0.frame_start_o) begin
        if (fs1 < 0) fs1 = cyc;
        else if (fs2 < 0) fs2 = cyc;
      end
      if (if0.vblank_irq_o && irq_rise < 0) irq_rise = cyc;
    end
    check("frame_de_cycles", fde_cnt, HA * VA);
    check("frame_hs_low", hs_low, HS * VT);
    check("frame_vs_low", vs_low, VS * HT);
    check("first_frame_start", fs1, 1);
    check("frame_period", fs2 - fs1, HT * VT);
    check("irq_rise_cycle", irq_rise, VA * HT + 1);

    // Single-cycle acknowledge clears the sticky flag.
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    check("irq_ack_clear", if0.vblank_irq_o, 0);

    // Acknowledge held across the set cycle: set wins, then the held ack clears it.
    wait_pos(VA * HT - 1);
    irq_ack = 1'b1;
    cycle();
    cycle();
    check("irq_set_wins", if0.vblank_irq_o, 1);
    cycle();
    check("irq_held_ack_clears", if0.vblank_irq_o, 0);
    irq_ack = 1'b0;
    wait_pos(VA * HT + 1);
    check("irq_set_again", if0.vblank_irq_o, 1);

    // Drop en in the middle of active line 2.
    wait_pos(2 * HT + 3);
    en = 1'b0;
    cycle();
    check("en_off_fetch_de", if0.fetch_de_o, 0);
    cycle();
    check("en_off_de_lag", if0.de_o, 1);
    cycle();
    check("en_off_de", if0.de_o, 0);
    repeat (3) cycle();
    check("en_off_h_sync", if0.h_sync_o, 1);
    check("en_off_v_sync", if0.v_sync_o, 1);
    check("en_off_irq_kept", if0.vblank_irq_o, 1);
    en = 1'b1;
    cycle();
    check("reen_frame_start", if0.frame_start_o, 1);
    check("reen_posx", if0.posx, 0);
    check("reen_posy", if0.posy, 0);
    cycle();
    check("reen_single_pulse", if0.frame_start_o, 0);
    check("reen_posx_step", if0.posx, 1);

    // Randomised enable gaps and acknowledges.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 63) != 0);
      irq_ack = ($urandom_range(0, 7) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of the active area, between clock edges.
    en = 1'b1;
    irq_ack = 1'b0;
    wait_pos(HT + 4);
    #1 rst_n = 1'b0;
    #1;
    check_all();
    check("async_rst_fetch_de", if0.fetch_de_o, 0);
    check("async_rst_posx", if0.posx, 0);
    check("async_rst_irq", if0.vblank_irq_o, 0);
    check("async_rst_h_sync_pol1", if1.h_sync_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default geometry: one and a bit 800-cycle lines.
    r1 = -1; r2 = -1; hfall = -1; hrise = -1; vs2_low = 0; de2_cnt = 0;
    prev_de = 1'b0; prev_hs = 1'b1;
    for (int cyc = 1; cyc <= 1700; cyc++) begin
      cycle();
      if (if2.de_o && !prev_de) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      if (!if2.h_sync_o && prev_hs && hfall < 0) hfall = cyc;
      if (if2.h_sync_o && !prev_hs && hrise < 0) hrise = cyc;
      if (!if2.v_sync_o) vs2_low++;
      if (cyc >= 3 && cyc < 803 && if2.de_o) de2_cnt++;
      prev_de = if2.de_o;
      prev_hs = if2.h_sync_o;
    end
    check("dflt_first_de", r1, 3);
    check("dflt_line_period", r2 - r1, 800);
    check("dflt_de_width", de2_cnt, 640);
    check("dflt_hsync_offset", hfall - r1, 656);
    check("dflt_hsync_width", hrise - hfall, 96);
    check("dflt_vsync_idle", vs2_low, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Replaces hard-coded 640x480 counter logic in the adapter top level.
- Produces h/v sync, data-enable, pixel/line coordinates and character-cell coordinates.
- Has a fetch-ahead output stage so screen/char RAM latency is absorbed before display.
- Adds frame/line strobes and a sticky vblank interrupt with acknowledge.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync width, lines
- V_BP, 33: vertical back porch, lines
- H_POL, 0: hsync active level (0 = active-low)
- V_POL, 0: vsync active level (0 = active-low)
- LEAD, 2: cycles the fetch-side outputs lead the display-side outputs (0 allowed)
- CELL_W, 8: character cell width, pixels (>=1)
- CELL_H, 8: character cell height, lines (>=1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- en  in  1  timing enable
- irq_ack  in  1  clears vblank_irq_o
- posx  out  clog2(H_ACTIVE)  fetch-side pixel x
- posy  out  clog2(V_ACTIVE)  fetch-side pixel y
- cell_col  out  clog2(H_ACTIVE/CELL_W+1)  fetch-side cell column
- cell_row  out  clog2(V_ACTIVE/CELL_H+1)  fetch-side cell row
- sub_x  out  clog2(CELL_W+1)  x within cell
- sub_y  out  clog2(CELL_H+1)  y within cell
- fetch_de_o  out  1  fetch-side active
- line_start_o  out  1  fetch-side pulse, first pixel of each active line
- frame_start_o  out  1  fetch-side pulse, pixel (0,0)
- de_o  out  1  display-side active
- h_sync_o  out  1  display-side hsync
- v_sync_o  out  1  display-side vsync
- vblank_irq_o  out  1  sticky vblank flag

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values:
  - Counters 0.
  - All coordinates 0.
  - fetch_de_o, de_o, line_start_o, frame_start_o, vblank_irq_o = 0.
  - h_sync_o = ~H_POL; v_sync_o = ~V_POL.
  - LEAD pipeline cleared to these inactive values.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters.
  - v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - v_cnt wraps to 0 after V_TOTAL-1.
- Fetch side: all outputs are registered from the counters, giving exactly 1 cycle latency.
  - fetch_de_o = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - posx = h_cnt and posy = v_cnt when active; both forced to 0 otherwise.
  - cell_col/sub_x and cell_row/sub_y are maintained by wrap counters; no dividers.
    - sub_x wraps at CELL_W-1 and increments cell_col; both reset at line start.
    - sub_y wraps at CELL_H-1 and increments cell_row; both reset at frame start.
    - All four read 0 outside the active area.
  - line_start_o = 1 for h_cnt=0 with v_cnt < V_ACTIVE.
  - frame_start_o = 1 for h_cnt=0, v_cnt=0.
- Display side: de_o and the sync outputs are the fetch-side timing delayed by exactly LEAD registers.
  - Raw hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Raw vsync is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, across whole lines, with edges aligned to h_cnt=0.
  - Output levels are XORed so the active level equals H_POL/V_POL.
- vblank_irq_o:
  - Set on the cycle after counters reach (h=0, v=V_ACTIVE).
  - Cleared by irq_ack.
  - Set and ack on the same cycle: set wins.
  - Stays set until acked, across frames.
- en low:
  - Counters synchronously return to (0,0) and hold.
  - Fetch outputs become inactive and 0 after 1 cycle.
  - The pipeline keeps shifting, so display outputs go inactive after 1+LEAD cycles.
  - vblank_irq_o keeps its value.
- en rising: the first frame starts at (0,0); frame_start_o pulses 1 cycle later.
- Reset mid-frame: immediate return to reset values, no partial pulses.

Test Plan (bench parameters H 8/2/3/1, V 4/1/2/1, LEAD=2, CELL_W=4, CELL_H=2, unless noted):
- Reset release, en=1:
  - fetch_de_o high 8 cycles of every 14-cycle line, for lines 0-3; frame period 112 cycles.
  - posx 0..7; sub_x 0,1,2,3,0,1,2,3; cell_col 0,0,0,0,1,1,1,1.
  - cell_row goes 0,0,1,1 over lines 0-3.
- Same run, display side:
  - de_o equals fetch_de_o delayed exactly 2 cycles.
  - h_sync_o low 3 cycles, falling 10 cycles after de_o rises.
  - v_sync_o low for 28 cycles, starting at the line-5 boundary.
- vblank_irq_o:
  - Rises 1 cycle after line 4 begins.
  - A single-cycle irq_ack clears it.
  - irq_ack held high across the set cycle leaves it 1.
- H_POL=1, V_POL=1: syncs 0 in reset and high only during the pulse windows.
- en dropped mid-line 2:
  - fetch_de_o 0 next cycle; de_o 0 after 3 cycles.
  - Syncs inactive; irq unchanged.
  - On re-enable, frame_start_o pulses once after 1 cycle, and posx/posy restart at 0.
- rst_n asserted asynchronously mid-active:
  - All outputs reach reset values without a clock edge.
  - Default parameters after release: 800x525 total, hsync 96 cycles, vsync 2 lines.
